// File: rtl/dbus_ctrl.sv
// rtl/dbus_ctrl.sv - memory-stage data-bus sequencer: addr_ok/data_ok handshake, strobes, load extend, stall
// Optional request/stall performance counters are built when DBUS_CTRL_PERF_EN is defined.
package dbus_pkg;
   typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2} msize_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;
endpackage

module dbus_ctrl
   import dbus_pkg::*;
#(
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              is_store,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              flush,
   input  dbus_resp_t        dresp,
   output dbus_req_t         dreq,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              misaligned,
   output logic              stall,
   output logic [PERF_W-1:0] perf_req_cnt,
   output logic [PERF_W-1:0] perf_stall_cnt
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [1:0]  size_q;
   logic        store_q, sext_q, mis_q, discard_q;
   logic        mis_in, accept, capture;
   logic [31:0] shifted, ext;

   // size 3 is handled as a word everywhere, hence the size[1] test
   assign mis_in = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'b00);

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: if (start && !flush) begin
            accept   = 1'b1;
            state_nx = mis_in ? DONE : REQ;
         end
         REQ: if (dresp.addr_ok) begin
            if (dresp.data_ok) begin
               capture  = 1'b1;
               state_nx = DONE;
            end else begin
               state_nx = WAIT;
            end
         end
         WAIT: if (dresp.data_ok) begin
            capture  = 1'b1;
            state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      shifted = dresp.data >> {addr_q[1:0], 3'b000};
      ext     = shifted;
      if (store_q)
         ext = '0;
      else if (size_q == 2'd0)
         ext = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      else if (size_q == 2'd1)
         ext = {{16{sext_q & shifted[15]}}, shifted[15:0]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         size_q    <= '0;
         store_q   <= 1'b0;
         sext_q    <= 1'b0;
         mis_q     <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            addr_q    <= addr;
            wdata_q   <= wdata;
            size_q    <= size;
            store_q   <= is_store;
            sext_q    <= sign_ext;
            mis_q     <= mis_in;
            discard_q <= 1'b0;
            rdata_q   <= '0;
         end else if ((state == REQ || state == WAIT) && flush) begin
            // bus transaction must still finish; only its result is dropped
            discard_q <= 1'b1;
         end
         if (capture)
            rdata_q <= ext;
      end
   end

   assign done       = (state == DONE) && !discard_q && !flush;
   assign misaligned = done && mis_q;
   assign rdata      = rdata_q;
   assign stall      = resetn && start && !flush && (state != DONE);

   always_comb begin
      dreq       = '0;
      dreq.valid = (state == REQ);
      dreq.addr  = addr_q;
      case (size_q)
         2'd0: begin
            dreq.size   = MSIZE1;
            dreq.strobe = 4'b0001 << addr_q[1:0];
            dreq.data   = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            dreq.size   = MSIZE2;
            dreq.strobe = 4'b0011 << addr_q[1:0];
            dreq.data   = {2{wdata_q[15:0]}};
         end
         default: begin
            dreq.size   = MSIZE4;
            dreq.strobe = 4'b1111;
            dreq.data   = wdata_q;
         end
      endcase
      if (!store_q)
         dreq.strobe = 4'b0000;
   end

`ifdef DBUS_CTRL_PERF_EN
   logic [PERF_W-1:0] req_cnt, stall_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (state == REQ && dresp.addr_ok)
            req_cnt <= req_cnt + PERF_W'(1);
         if (stall)
            stall_cnt <= stall_cnt + PERF_W'(1);
      end
   end

   assign perf_req_cnt   = req_cnt;
   assign perf_stall_cnt = stall_cnt;
`else
   assign perf_req_cnt   = '0;
   assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_dbus_ctrl.sv
// tb/tb_dbus_ctrl.sv - self-checking bench for dbus_ctrl
module tb_dbus_ctrl;
   import dbus_pkg::*;

   logic        clk = 1'b0;
   logic        resetn, start, is_store, sign_ext, flush;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;
   dbus_resp_t  dresp;
   dbus_req_t   dreq;
   logic        done, misaligned, stall;
   logic [31:0] perf_req_cnt, perf_stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        st;
      logic [1:0]  sz;
      logic        sx;
      logic [31:0] a, wd, bus;
      int          ad, dd;
      logic [3:0]  strb;
      logic [31:0] wdat;
      logic [1:0]  msz;
      logic [31:0] rd;
      logic        mis;
      int          lat;
   } vec_t;

   dbus_ctrl #(.PERF_W(32)) dut (
      .clk(clk), .resetn(resetn), .start(start), .is_store(is_store), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .flush(flush), .dresp(dresp),
      .dreq(dreq), .rdata(rdata), .done(done), .misaligned(misaligned), .stall(stall),
      .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic st, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, wd, bus, input int ad, dd,
                                input logic [3:0] strb, input logic [31:0] wdat,
                                input logic [1:0] msz, input logic [31:0] rd,
                                input logic mis, input int lat);
      vec_t v;
      v.st = st; v.sz = sz; v.sx = sx; v.a = a; v.wd = wd; v.bus = bus; v.ad = ad; v.dd = dd;
      v.strb = strb; v.wdat = wdat; v.msz = msz; v.rd = rd; v.mis = mis; v.lat = lat;
      return v;
   endfunction

   // Reference model: derives every expectation from byte counts and arithmetic
   function automatic vec_t model(input logic st, input logic [1:0] sz, input logic sx,
                                  input logic [31:0] a, wd, bus, input int ad, dd);
      vec_t        v;
      int          nb, off;
      logic [31:0] mask, raw;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off = int'(a % 4);
      v.st = st; v.sz = sz; v.sx = sx; v.a = a; v.wd = wd; v.bus = bus; v.ad = ad; v.dd = dd;
      v.mis  = (a % nb) != 0;
      v.msz  = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
      v.strb = st ? 4'(((1 << nb) - 1) << off) : 4'd0;
      case (nb)
         1:       v.wdat = (wd % 256) * 32'h01010101;
         2:       v.wdat = (wd % 65536) * 32'h00010001;
         default: v.wdat = wd;
      endcase
      mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
      raw  = (bus >> (8 * off)) & mask;
      if (sx && nb < 4 && raw > (mask >> 1))
         raw = raw | ~mask;
      v.rd  = st ? 32'd0 : raw;
      v.lat = v.mis ? 1 : 2 + ad + dd;
      return v;
   endfunction

   // One access with a slave giving addr_ok after ad valid cycles and data_ok dd cycles later
   task automatic run_access(input vec_t v);
      int cyc, vcnt, since;
      bit fin;
      cyc = 0; vcnt = 0; since = -1; fin = 0;
      @(negedge clk);
      start = 1'b1; is_store = v.st; size = v.sz; sign_ext = v.sx;
      addr = v.a; wdata = v.wd; flush = 1'b0;
      while (!fin) begin
         dresp = '0;
         dresp.data = $urandom;
         if (dreq.valid) begin
            if (vcnt == v.ad) begin
               dresp.addr_ok = 1'b1;
               if (v.dd == 0) begin
                  dresp.data_ok = 1'b1;
                  dresp.data    = v.bus;
               end else begin
                  since = 0;
               end
            end
            vcnt++;
         end else if (since >= 0) begin
            since++;
            if (since == v.dd) begin
               dresp.data_ok = 1'b1;
               dresp.data    = v.bus;
               since         = -1;
            end
         end
         #1;
         if (dreq.valid) begin
            chk("req_addr", dreq.addr, v.a);
            chk("req_size", dreq.size, v.msz);
            chk("req_strobe", dreq.strobe, v.strb);
            if (v.st) chk("req_data", dreq.data, v.wdat);
         end
         if (done) begin
            chk("latency", cyc, v.lat);
            chk("misaligned", misaligned, v.mis);
            if (!v.mis) chk("rdata", rdata, v.rd);
            chk("stall_at_done", stall, 1'b0);
            fin = 1;
         end else begin
            chk("stall_busy", stall, 1'b1);
            if (cyc >= 60) begin
               chk("done_timeout", 1'b0, 1'b1);
               fin = 1;
            end
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      dresp = '0;
      #1;
      chk("done_pulse_len", done, 1'b0);
      chk("stall_after", stall, 1'b0);
      chk("valid_cycles", vcnt, v.mis ? 0 : v.ad + 1);
   endtask

   // mode 0: flush in REQ; 1: flush in WAIT before data_ok; 2: flush together with data_ok
   task automatic flush_seq(input int mode);
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; size = 2'd2; sign_ext = 1'b0;
      addr = 32'h8000_0020; flush = 1'b0; dresp = '0;
      @(negedge clk);
      if (mode == 0) begin
         flush = 1'b1; #1;
         chk("flush_req_valid", dreq.valid, 1'b1);
         chk("flush_req_stall", stall, 1'b0);
         @(negedge clk);
         flush = 1'b0; start = 1'b0;
         dresp.addr_ok = 1'b1; dresp.data_ok = 1'b1; dresp.data = 32'h1111_2222; #1;
         chk("flush_req_hold", dreq.valid, 1'b1);
      end else begin
         dresp.addr_ok = 1'b1; #1;
         chk("flush_w_valid", dreq.valid, 1'b1);
         @(negedge clk);
         dresp = '0;
         flush = (mode == 1); #1;
         chk("flush_w_noval", dreq.valid, 1'b0);
         chk("flush_w_stall", stall, mode == 1 ? 1'b0 : 1'b1);
         @(negedge clk);
         flush = (mode == 2); start = (mode == 2);
         dresp.data_ok = 1'b1; dresp.data = 32'h3333_4444; #1;
         if (mode == 2) chk("flush_dok_stall", stall, 1'b0);
         @(negedge clk);
         flush = 1'b0; start = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dresp = '0; #1;
         chk("flush_no_done", done, 1'b0);
         chk("flush_idle_noval", dreq.valid, 1'b0);
      end
   endtask

   vec_t tbl[10];
   vec_t rv;
   int   stall_sum;

   initial begin
      tbl[0] = mkv(0, 2, 0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 4'h0, 32'h0, 2, 32'hDEAD_BEEF, 0, 2);
      tbl[1] = mkv(1, 0, 0, 32'h8000_0003, 32'hA5, 32'h0, 3, 2, 4'h8, 32'hA5A5_A5A5, 0, 32'h0, 0, 7);
      tbl[2] = mkv(0, 1, 1, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0, 4'h0, 32'h0, 1, 32'hFFFF_8001, 0, 2);
      tbl[3] = mkv(0, 1, 0, 32'h8000_0002, 32'h0, 32'h8001_1234, 1, 0, 4'h0, 32'h0, 1, 32'h0000_8001, 0, 3);
      tbl[4] = mkv(0, 2, 0, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 2, 32'h0, 1, 1);
      tbl[5] = mkv(0, 0, 1, 32'h8000_0001, 32'h0, 32'h0000_8000, 1, 1, 4'h0, 32'h0, 0, 32'hFFFF_FF80, 0, 4);
      tbl[6] = mkv(1, 1, 0, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 0, 1, 4'hC, 32'hABCD_ABCD, 1, 32'h0, 0, 3);
      tbl[7] = mkv(0, 1, 0, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 1, 32'h0, 1, 1);
      tbl[8] = mkv(1, 3, 0, 32'h8000_0004, 32'h1122_3344, 32'h0, 2, 0, 4'hF, 32'h1122_3344, 2, 32'h0, 0, 4);
      tbl[9] = mkv(0, 0, 0, 32'h8000_0002, 32'h0, 32'h12FE_3456, 0, 3, 4'h0, 32'h0, 0, 32'h0000_00FE, 0, 5);

      resetn = 1'b0; start = 1'b1; is_store = 1'b0; size = 2'd0; sign_ext = 1'b0;
      addr = '0; wdata = '0; flush = 1'b0; dresp = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", dreq.valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_mis", misaligned, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_stall", stall, 1'b0);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 10; i++) run_access(tbl[i]);

      // flush in IDLE blocks acceptance
      @(negedge clk);
      start = 1'b1; flush = 1'b1; size = 2'd2; addr = 32'h8000_0040; is_store = 1'b0;
      @(negedge clk);
      start = 1'b0; flush = 1'b0; #1;
      chk("idle_flush_noreq", dreq.valid, 1'b0);
      @(negedge clk); #1;
      chk("idle_flush_noreq2", dreq.valid, 1'b0);

      for (int m = 0; m < 3; m++) begin
         flush_seq(m);
         run_access(tbl[0]);
      end

      for (int i = 0; i < 150; i++) begin
         rv = model($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                    $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
         run_access(rv);
      end

      // asynchronous reset while a request is outstanding
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; size = 2'd2; addr = 32'h8000_0080; dresp = '0;
      @(negedge clk); #1;
      chk("pre_rst_valid", dreq.valid, 1'b1);
      chk("pre_rst_stall", stall, 1'b1);
      #1 resetn = 1'b0;
      #1;
      chk("async_rst_valid", dreq.valid, 1'b0);
      chk("async_rst_stall", stall, 1'b0);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      stall_sum = 0;
      for (int i = 0; i < 3; i++) begin
         rv = model(1'b0, 2'd2, 1'b0, 32'h8000_0100 + 32'(4 * i), 32'h0, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2));
         stall_sum += rv.lat;
         run_access(rv);
      end
`ifdef DBUS_CTRL_PERF_EN
      chk("perf_req_cnt", perf_req_cnt, 32'd3);
      chk("perf_stall_cnt", perf_stall_cnt, stall_sum);
`else
      chk("perf_req_off", perf_req_cnt, 32'd0);
      chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
